// File: rtl/uart_cmd_dispatcher.sv
// UART command dispatcher: assembles command frames into per-channel step/dir holding registers.
// Optional macro CMD_CHECKSUM_EN adds a sixth XOR checksum byte to every frame.
module uart_cmd_dispatcher #(
  parameter int unsigned NUM_CH         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 262143,
  parameter int unsigned DIV_W          = 15,
  parameter int unsigned STEP_W         = 15
) (
  input  logic                       CLK,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic [NUM_CH-1:0]          motor_active,
  output logic [NUM_CH*DIV_W-1:0]    ch_divider,
  output logic [NUM_CH*STEP_W-1:0]   ch_steps,
  output logic [NUM_CH-1:0]          ch_dir,
  output logic [NUM_CH-1:0]          ch_pending,
  output logic [NUM_CH-1:0]          ch_load,
  output logic                       status_req,
  output logic                       frame_drop,
  output logic                       timeout
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] FrameLen = 3'd6;
`else
  localparam logic [2:0] FrameLen = 3'd5;
`endif

  typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

  state_e              state, stateNext;
  logic [2:0]          byteCnt, byteCntNext;
  logic [39:0]         cmd, cmdNext;
  logic [TimerW-1:0]   timer, timerNext;
  logic [NUM_CH-1:0]   activeQ, rise, loadVec, pendingNext;
  logic                statusNext, timeoutNext, commitOk, dropNext;
  logic [3:0]          chSel;
  logic [15:0]         pendPad;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]          cksum, cksumNext;
  logic                cksumOk;
`endif

  always_comb begin
    stateNext   = state;
    byteCntNext = byteCnt;
    cmdNext     = cmd;
    statusNext  = 1'b0;
    timeoutNext = 1'b0;
`ifdef CMD_CHECKSUM_EN
    cksumNext   = cksum;
`endif
    if (rx_valid) begin
      timerNext = TimerW'(TIMEOUT_CYCLES);
    end else if (timer != '0) begin
      timerNext = timer - TimerW'(1);
    end else begin
      timerNext = timer;
    end

    unique case (state)
      // A byte arriving during commit already starts the next frame.
      StIdle, StCommit: begin
        stateNext   = StIdle;
        byteCntNext = '0;
        if (rx_valid) begin
          if (rx_data[3:0] == 4'hF) begin
            statusNext = 1'b1;
          end else begin
            cmdNext     = {rx_data, cmd[39:8]};
            byteCntNext = 3'd1;
            stateNext   = StRecv;
          end
        end
      end
      StRecv: begin
        if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
          if (byteCnt == 3'd5) cksumNext = rx_data;
          else                 cmdNext   = {rx_data, cmd[39:8]};
`else
          cmdNext = {rx_data, cmd[39:8]};
`endif
          byteCntNext = byteCnt + 3'd1;
          if (byteCnt == FrameLen - 3'd1) stateNext = StCommit;
        end else if (timer == '0) begin
          stateNext   = StIdle;
          byteCntNext = '0;
          timeoutNext = 1'b1;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  assign chSel   = cmd[3:0];
  assign pendPad = 16'(ch_pending);
`ifdef CMD_CHECKSUM_EN
  assign cksumOk  = (cmd[7:0] ^ cmd[15:8] ^ cmd[23:16] ^ cmd[31:24] ^ cmd[39:32]) == cksum;
  assign commitOk = (state == StCommit) && (32'(chSel) < NUM_CH) && !pendPad[chSel] && cksumOk;
`else
  assign commitOk = (state == StCommit) && (32'(chSel) < NUM_CH) && !pendPad[chSel];
`endif
  assign dropNext = (state == StCommit) && !commitOk;

  always_comb begin
    loadVec = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      loadVec[c] = commitOk && (32'(chSel) == c);
    end
  end

  // Acceptance above uses pending before this cycle's clear.
  assign rise        = motor_active & ~activeQ;
  assign pendingNext = (ch_pending & ~rise) | loadVec;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state      <= StIdle;
      byteCnt    <= '0;
      cmd        <= '0;
      timer      <= '0;
      activeQ    <= '0;
      ch_divider <= '0;
      ch_steps   <= '0;
      ch_dir     <= '0;
      ch_pending <= '0;
      ch_load    <= '0;
      status_req <= 1'b0;
      frame_drop <= 1'b0;
      timeout    <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      state      <= stateNext;
      byteCnt    <= byteCntNext;
      cmd        <= cmdNext;
      timer      <= timerNext;
      activeQ    <= motor_active;
      ch_pending <= pendingNext;
      ch_load    <= loadVec;
      status_req <= statusNext;
      frame_drop <= dropNext;
      timeout    <= timeoutNext;
`ifdef CMD_CHECKSUM_EN
      cksum      <= cksumNext;
`endif
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (loadVec[c]) begin
          ch_divider[c*DIV_W +: DIV_W]  <= cmd[4 +: DIV_W];
          ch_steps[c*STEP_W +: STEP_W]  <= cmd[4+DIV_W +: STEP_W];
          ch_dir[c]                     <= cmd[4+DIV_W+STEP_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Self-checking bench for uart_cmd_dispatcher; frame-level reference model, randomized traffic.
module tb_uart_cmd_dispatcher;

  localparam int NUM_CH = 10;
  localparam int TO     = 40;
  localparam int DIV_W  = 15;
  localparam int STEP_W = 15;
`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  logic                      CLK;
  logic                      reset_n;
  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic [NUM_CH-1:0]         motor_active;
  logic [NUM_CH*DIV_W-1:0]   ch_divider;
  logic [NUM_CH*STEP_W-1:0]  ch_steps;
  logic [NUM_CH-1:0]         ch_dir;
  logic [NUM_CH-1:0]         ch_pending;
  logic [NUM_CH-1:0]         ch_load;
  logic                      status_req;
  logic                      frame_drop;
  logic                      timeout;

  int nVec = 0;
  int nErr = 0;

  logic [DIV_W-1:0]  expDiv   [NUM_CH];
  logic [STEP_W-1:0] expSteps [NUM_CH];
  logic              expDir   [NUM_CH];
  logic              expPend  [NUM_CH];
  logic [7:0]        fb       [6];

  uart_cmd_dispatcher #(
    .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO), .DIV_W(DIV_W), .STEP_W(STEP_W)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .motor_active(motor_active), .ch_divider(ch_divider), .ch_steps(ch_steps),
    .ch_dir(ch_dir), .ch_pending(ch_pending), .ch_load(ch_load),
    .status_req(status_req), .frame_drop(frame_drop), .timeout(timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      expDiv[c] = '0; expSteps[c] = '0; expDir[c] = 1'b0; expPend[c] = 1'b0;
    end
  endtask

  // Builds the frame bytes from field values; byte 0 carries the low bits.
  task automatic make_frame(input int ch, input int dv, input int st, input bit dr, input int hi);
    logic [39:0] c40;
    c40 = 40'(ch & 15) | (40'(dv & 'h7fff) << 4) | (40'(st & 'h7fff) << 19)
        | (40'(dr) << 34) | (40'(hi & 31) << 35);
    for (int i = 0; i < 5; i++) fb[i] = c40[8*i +: 8];
    fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_motor(input int c);
    logic [NUM_CH-1:0] ePend;
    motor_active[c] = 1'b1;
    @(negedge CLK);
    expPend[c] = 1'b0;
    for (int k = 0; k < NUM_CH; k++) ePend[k] = expPend[k];
    nVec++;
    if (ch_pending !== ePend) begin
      nErr++;
      $display("FAIL pend_clear ch%0d ch_pending got %h want %h", c, ch_pending, ePend);
    end
    motor_active[c] = 1'b0;
    @(negedge CLK);
  endtask

  // Sends fb, optionally raising motor_active[riseCh] in the commit cycle, and checks the result.
  task automatic run_frame(input string name, input int gap, input int riseCh);
    logic [39:0] c40;
    int ch;
    bit ok;
    logic [NUM_CH-1:0] eLoad, ePend;
    logic [NUM_CH*DIV_W+NUM_CH*STEP_W+NUM_CH-1:0] eRegs;
    for (int i = 0; i < FRAME_LEN; i++) send_byte(fb[i], gap);
    c40 = {fb[4], fb[3], fb[2], fb[1], fb[0]};
    ch  = int'(c40[3:0]);
    ok  = (ch < NUM_CH);
    if (ok) ok = !expPend[ch];
`ifdef CMD_CHECKSUM_EN
    if (fb[5] != (fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4])) ok = 1'b0;
`endif
    if (riseCh >= 0) begin
      motor_active[riseCh] = 1'b1;
      expPend[riseCh] = 1'b0;
    end
    eLoad = '0;
    if (ok) begin
      expDiv[ch]   = DIV_W'(c40 >> 4);
      expSteps[ch] = STEP_W'(c40 >> 19);
      expDir[ch]   = c40[34];
      expPend[ch]  = 1'b1;
      eLoad[ch]    = 1'b1;
    end
    @(negedge CLK);
    for (int k = 0; k < NUM_CH; k++) begin
      ePend[k] = expPend[k];
      eRegs[NUM_CH*STEP_W + NUM_CH + k*DIV_W +: DIV_W] = expDiv[k];
      eRegs[NUM_CH + k*STEP_W +: STEP_W] = expSteps[k];
      eRegs[k] = expDir[k];
    end
    nVec++;
    if ({ch_load, frame_drop} !== {eLoad, !ok}) begin
      nErr++;
      $display("FAIL %s load/drop got %h/%b want %h/%b", name, ch_load, frame_drop, eLoad, !ok);
    end
    nVec++;
    if (ch_pending !== ePend) begin
      nErr++;
      $display("FAIL %s ch_pending got %h want %h", name, ch_pending, ePend);
    end
    nVec++;
    if ({ch_divider, ch_steps, ch_dir} !== eRegs) begin
      nErr++;
      $display("FAIL %s regs got %h want %h", name, {ch_divider, ch_steps, ch_dir}, eRegs);
    end
    if (riseCh >= 0) motor_active[riseCh] = 1'b0;
    @(negedge CLK);
    nVec++;
    if ({ch_load, frame_drop} !== '0) begin
      nErr++;
      $display("FAIL %s strobe_len load/drop got %h/%b want 0/0", name, ch_load, frame_drop);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    model_reset();
    @(negedge CLK);
    nVec++;
    if ({ch_divider, ch_steps, ch_dir, ch_pending, ch_load, status_req, frame_drop, timeout}
        !== '0) begin
      nErr++;
      $display("FAIL reset outputs got nonzero want 0 (pending %h load %h)", ch_pending, ch_load);
    end
  endtask

  task automatic test_basic();
    fb = '{8'h02, 8'h10, 8'h80, 8'h00, 8'h04, 8'h96};
    run_frame("basic", 9, -1);
    nVec++;
    if ({ch_divider[2*DIV_W +: DIV_W], ch_steps[2*STEP_W +: STEP_W], ch_dir[2], ch_pending}
        !== {15'h0100, 15'h0010, 1'b1, 10'h004}) begin
      nErr++;
      $display("FAIL basic_fields got div %h steps %h dir %b pend %h want 0100 0010 1 004",
               ch_divider[2*DIV_W +: DIV_W], ch_steps[2*STEP_W +: STEP_W], ch_dir[2], ch_pending);
    end
  endtask

  task automatic test_repeat();
    fb = '{8'h02, 8'h10, 8'h80, 8'h00, 8'h04, 8'h96};
    run_frame("repeat_drop", 2, -1);
    pulse_motor(2);
    make_frame(2, 'h200, 'h10, 1'b1, 0);
    run_frame("resend", 1, -1);
  endtask

  task automatic test_status();
    logic [7:0] sb [2];
    sb = '{8'h0F, 8'h3F};
    for (int i = 0; i < 2; i++) begin
      send_byte(sb[i], 2);
      nVec++;
      if (status_req !== 1'b1) begin
        nErr++;
        $display("FAIL status_%0d status_req got %b want 1", i, status_req);
      end
      @(negedge CLK);
      nVec++;
      if ({status_req, frame_drop, ch_load} !== '0) begin
        nErr++;
        $display("FAIL status_%0d_end status/drop/load got %b/%b/%h want 0", i, status_req,
                 frame_drop, ch_load);
      end
    end
    make_frame(7, $urandom_range(0, 'h7fff), $urandom_range(0, 'h7fff), 1'b0, 0);
    run_frame("after_status", 0, -1);
  endtask

  task automatic test_timeout();
    int first = -1;
    int cnt   = 0;
    send_byte(8'h02, 3);
    send_byte(8'h10, 3);
    for (int i = 1; i <= TO + 10; i++) begin
      if (timeout === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      @(negedge CLK);
    end
    nVec++;
    if (cnt != 1 || first != TO + 2) begin
      nErr++;
      $display("FAIL timeout pulses got %0d at %0d want 1 at %0d", cnt, first, TO + 2);
    end
    make_frame(3, $urandom_range(0, 'h7fff), $urandom_range(0, 'h7fff), 1'b1, 5);
    run_frame("after_timeout", 2, -1);
  endtask

  task automatic test_bad_channel();
    make_frame(12, 'h1234, 'h0567, 1'b1, 0);
    run_frame("bad_channel", 1, -1);
  endtask

  task automatic test_mid_reset();
    make_frame(1, 'h0aaa, 'h0555, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_byte(fb[i], 1);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    model_reset();
    nVec++;
    if ({ch_divider, ch_steps, ch_dir, ch_pending, ch_load, status_req, frame_drop, timeout}
        !== '0) begin
      nErr++;
      $display("FAIL mid_reset outputs got nonzero want 0 (pending %h)", ch_pending);
    end
    make_frame(1, 'h7001, 'h0042, 1'b0, 3);
    run_frame("after_reset", 1, -1);
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum();
    fb = '{8'h02, 8'h10, 8'h80, 8'h00, 8'h04, 8'h97};
    run_frame("cksum_bad", 1, -1);
    fb[5] = 8'h96;
    run_frame("cksum_good", 1, -1);
  endtask
`endif

  task automatic test_simultaneous();
    make_frame(4, 'h0100, 'h0200, 1'b0, 0);
    run_frame("sim_setup", 0, -1);
    make_frame(4, 'h0300, 'h0400, 1'b1, 0);
    run_frame("sim_same_ch", 0, 4);
    make_frame(6, 'h0123, 'h0321, 1'b1, 0);
    run_frame("sim_setup_b", 0, -1);
    make_frame(8, 'h0777, 'h0666, 1'b0, 0);
    run_frame("sim_other_ch", 0, 6);
  endtask

  task automatic test_random();
    int ch;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_motor($urandom_range(0, NUM_CH - 1));
      end else begin
        ch = $urandom_range(0, 14);
        make_frame(ch, $urandom_range(0, 'h7fff), $urandom_range(0, 'h7fff),
                   1'($urandom_range(0, 1)), $urandom_range(0, 31));
        if (ch < NUM_CH && $urandom_range(0, 9) == 0) run_frame("rand_rise", 0, ch);
        else run_frame("rand", $urandom_range(0, 3), -1);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    rx_data      = '0;
    rx_valid     = 1'b0;
    motor_active = '0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_basic();
    test_repeat();
    test_status();
    test_timeout();
    test_bad_channel();
    test_mid_reset();
`ifdef CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
